// File: rtl/reg_file_wb_pkg.sv
//------------------------------------------------------------------------------
// Module : reg_file_wb_pkg
// Brief  : Shared register-file constants, indices and scoreboard op helper.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package reg_file_wb_pkg;

   localparam int REG_ADDR_WIDTH = 5;
   localparam int REG_DATA_WIDTH = 32;
   localparam int REG_COUNT      = 2 ** REG_ADDR_WIDTH;

   localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
   localparam logic [REG_ADDR_WIDTH-1:0] REG_AT   = 5'd1;
   localparam logic [REG_ADDR_WIDTH-1:0] REG_V0   = 5'd2;
   localparam logic [REG_ADDR_WIDTH-1:0] REG_GP   = 5'd28;
   localparam logic [REG_ADDR_WIDTH-1:0] REG_SP   = 5'd29;
   localparam logic [REG_ADDR_WIDTH-1:0] REG_FP   = 5'd30;
   localparam logic [REG_ADDR_WIDTH-1:0] REG_RA   = 5'd31;

   typedef enum logic [1:0] {
      SB_HOLD = 2'd0,
      SB_INC  = 2'd1,
      SB_DEC  = 2'd2
   } sb_op_e;

   // A producer entering and one retiring in the same cycle cancel out.
   function automatic sb_op_e sb_op_decode(input logic inc, input logic dec);
      sb_op_e op;
      op = SB_HOLD;
      if (inc && !dec) op = SB_INC;
      if (dec && !inc) op = SB_DEC;
      return op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/reg_sb_counter.sv
//------------------------------------------------------------------------------
// Module : reg_sb_counter
// Brief  : Saturating in-flight producer counter with clear and misuse flag.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_sb_counter
   import reg_file_wb_pkg::*;
#(
   parameter int CNT_WIDTH = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clr_i,
   input  logic                 inc_i,
   input  logic                 dec_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 err_o
);

   localparam logic [CNT_WIDTH-1:0] C_MAX = {CNT_WIDTH{1'b1}};

   logic [CNT_WIDTH-1:0] cnt_q;
   sb_op_e               w_op;

   assign w_op  = sb_op_decode(inc_i, dec_i);
   assign cnt_o = cnt_q;

   // A clear squashes the issuing instruction, so neither edge case is an error.
   assign err_o = !clr_i && (((w_op == SB_INC) && (cnt_q == C_MAX)) ||
                             ((w_op == SB_DEC) && (cnt_q == '0)));

   always_ff @(posedge clk) begin
      if (reset || clr_i) begin
         cnt_q <= '0;
      end else if ((w_op == SB_INC) && (cnt_q != C_MAX)) begin
         cnt_q <= cnt_q + 1'b1;
      end else if ((w_op == SB_DEC) && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/reg_file_wb.sv
//------------------------------------------------------------------------------
// Module : reg_file_wb
// Brief  : 32x32 register file, write-through read ports, producer scoreboard.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_file_wb
   import reg_file_wb_pkg::*;
#(
   parameter int DATA_WIDTH = REG_DATA_WIDTH,
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
   parameter int CNT_WIDTH  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  issue_en,
   input  logic [ADDR_WIDTH-1:0] issue_addr,
   input  logic                  flush,
   input  logic [ADDR_WIDTH-1:0] rd_addr_a,
   input  logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic [DATA_WIDTH-1:0] rd_data_a,
   output logic [DATA_WIDTH-1:0] rd_data_b,
   output logic                  busy_a,
   output logic                  busy_b,
   output logic                  sb_err
);

   localparam int NREGS = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] C_ZERO = ADDR_WIDTH'(REG_ZERO);

   logic [NREGS-1:0][DATA_WIDTH-1:0] regs_q;
   logic [NREGS-1:0][CNT_WIDTH-1:0]  w_cnt;
   logic [NREGS-1:0]                 w_err;
   logic [NREGS-1:0]                 w_wr_dec;
   logic [NREGS-1:0]                 w_iss_dec;
   logic                             sb_err_q;
   logic                             sb_err_d;
   logic                             w_hit_a;
   logic                             w_hit_b;
   logic [CNT_WIDTH-1:0]             w_pend_a;
   logic [CNT_WIDTH-1:0]             w_pend_b;

   always_comb begin
      w_wr_dec  = '0;
      w_iss_dec = '0;
      if (wr_en && (wr_addr != C_ZERO))        w_wr_dec[wr_addr]     = 1'b1;
      if (issue_en && (issue_addr != C_ZERO))  w_iss_dec[issue_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q <= '0;
      end else begin
         for (int r = 1; r < NREGS; r++) begin
            if (w_wr_dec[r]) regs_q[r] <= wr_data;
         end
      end
   end

   // Register 0 has no producer tracking; it can never be busy.
   assign w_cnt[0] = '0;
   assign w_err[0] = 1'b0;

   generate
      for (genvar r = 1; r < NREGS; r++) begin : g_sb
         reg_sb_counter #(
            .CNT_WIDTH (CNT_WIDTH)
         ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr_i (flush),
            .inc_i (w_iss_dec[r]),
            .dec_i (w_wr_dec[r]),
            .cnt_o (w_cnt[r]),
            .err_o (w_err[r])
         );
      end
   endgenerate

   assign sb_err_d = sb_err_q | (|w_err);

   always_ff @(posedge clk) begin
      if (reset) sb_err_q <= 1'b0;
      else       sb_err_q <= sb_err_d;
   end

   assign sb_err = sb_err_q;

   assign w_hit_a = wr_en && (wr_addr == rd_addr_a);
   assign w_hit_b = wr_en && (wr_addr == rd_addr_b);

   always_comb begin
      rd_data_a = regs_q[rd_addr_a];
      if (w_hit_a)                rd_data_a = wr_data;
      if (rd_addr_a == C_ZERO)    rd_data_a = '0;
      rd_data_b = regs_q[rd_addr_b];
      if (w_hit_b)                rd_data_b = wr_data;
      if (rd_addr_b == C_ZERO)    rd_data_b = '0;
   end

   // A write retiring this cycle is bypassed, so it no longer counts as pending.
   assign w_pend_a = w_cnt[rd_addr_a] - CNT_WIDTH'(w_hit_a);
   assign w_pend_b = w_cnt[rd_addr_b] - CNT_WIDTH'(w_hit_b);
   assign busy_a   = (rd_addr_a != C_ZERO) && (w_pend_a != '0);
   assign busy_b   = (rd_addr_b != C_ZERO) && (w_pend_b != '0);

endmodule

`default_nettype wire

// File: tb/tb_reg_file_wb.sv
//------------------------------------------------------------------------------
// Module : tb_reg_file_wb
// Brief  : Self-checking bench for reg_file_wb against an array-based model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_file_wb;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        issue_en;
   logic [4:0]  issue_addr;
   logic        flush;
   logic [4:0]  rd_addr_a;
   logic [4:0]  rd_addr_b;
   logic [31:0] rd_data_a;
   logic [31:0] rd_data_b;
   logic        busy_a;
   logic        busy_b;
   logic        sb_err;

   int          n_checks = 0;
   int          n_fail   = 0;

   logic [31:0] mregs [32];
   int          mcnt  [32];
   logic        merr;

   always #5 clk = ~clk;

   reg_file_wb dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .flush      (flush),
      .rd_addr_a  (rd_addr_a),
      .rd_addr_b  (rd_addr_b),
      .rd_data_a  (rd_data_a),
      .rd_data_b  (rd_data_b),
      .busy_a     (busy_a),
      .busy_b     (busy_b),
      .sb_err     (sb_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 0)                      return 32'd0;
      if (wr_en && wr_addr == a)       return wr_data;
      return mregs[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      int pend;
      if (a == 0) return 1'b0;
      pend = mcnt[a] - ((wr_en && wr_addr == a) ? 1 : 0);
      return pend != 0;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < 32; r++) begin
         mregs[r] = 32'd0;
         mcnt[r]  = 0;
      end
      merr = 1'b0;
   endtask

   task automatic model_edge();
      int inc, dec;
      if (reset) begin
         model_clear();
         return;
      end
      if (wr_en && wr_addr != 0) mregs[wr_addr] = wr_data;
      for (int r = 1; r < 32; r++) begin
         if (flush) begin
            mcnt[r] = 0;
         end else begin
            inc = (issue_en && issue_addr == r) ? 1 : 0;
            dec = (wr_en && wr_addr == r) ? 1 : 0;
            if (inc == 1 && dec == 0) begin
               if (mcnt[r] == 3) merr = 1'b1;
               else              mcnt[r] = mcnt[r] + 1;
            end else if (dec == 1 && inc == 0) begin
               if (mcnt[r] == 0) merr = 1'b1;
               else              mcnt[r] = mcnt[r] - 1;
            end
         end
      end
   endtask

   task automatic step(input string tag);
      #1;
      check({tag, ":rd_a"},   rd_data_a,      exp_rd(rd_addr_a));
      check({tag, ":rd_b"},   rd_data_b,      exp_rd(rd_addr_b));
      check({tag, ":busy_a"}, 32'(busy_a),    32'(exp_busy(rd_addr_a)));
      check({tag, ":busy_b"}, 32'(busy_b),    32'(exp_busy(rd_addr_b)));
      check({tag, ":sb_err"}, 32'(sb_err),    32'(merr));
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic cyc(input string tag,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ie, input logic [4:0] ia, input logic fl,
                      input logic [4:0] ra, input logic [4:0] rb);
      reset = 1'b0; wr_en = we; wr_addr = wa; wr_data = wd;
      issue_en = ie; issue_addr = ia; flush = fl;
      rd_addr_a = ra; rd_addr_b = rb;
      step(tag);
   endtask

   task automatic do_reset(input logic [4:0] ra, input logic [4:0] rb);
      reset = 1'b1; wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
      rd_addr_a = ra; rd_addr_b = rb;
      step("reset");
      reset = 1'b0;
   endtask

   function automatic logic [4:0] pick_addr();
      logic [4:0] hot [4];
      hot[0] = 5'd0; hot[1] = 5'd1; hot[2] = 5'd12; hot[3] = 5'd31;
      if ($urandom_range(0, 1) == 1) return hot[$urandom_range(0, 3)];
      return 5'($urandom_range(0, 31));
   endfunction

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
      rd_addr_a = '0; rd_addr_b = '0;
      model_clear();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // reset state and register 0
      cyc("rst_rd",   0, 0, 0,            0, 0, 0, 5,  0);
      cyc("wr_r0",    1, 0, 32'hFFFFFFFF, 0, 0, 0, 0,  0);
      cyc("rd_r0",    0, 0, 0,            0, 0, 0, 0,  0);

      // write-through bypass
      cyc("byp8",     1, 8, 32'hDEADBEEF, 0, 0, 0, 8,  0);
      cyc("hold8",    0, 0, 0,            0, 0, 0, 8,  8);

      // two producers of r9
      cyc("iss9a",    0, 0, 0,            1, 9, 0, 9,  0);
      cyc("iss9b",    0, 0, 0,            1, 9, 0, 9,  0);
      cyc("idle9",    0, 0, 0,            0, 0, 0, 9,  0);
      cyc("wr9a",     1, 9, 32'h00000009, 0, 0, 0, 9,  0);
      cyc("wr9b",     1, 9, 32'h00000099, 0, 0, 0, 9,  9);
      cyc("done9",    0, 0, 0,            0, 0, 0, 9,  9);

      // simultaneous issue and retire
      cyc("iss12",    0, 0, 0,            1, 12, 0, 0, 12);
      cyc("both12",   1, 12, 32'h0000C0DE, 1, 12, 0, 0, 12);
      cyc("after12",  0, 0, 0,            0, 0, 0, 12, 12);
      cyc("ret12",    1, 12, 32'h00001212, 0, 0, 0, 12, 0);
      cyc("clean12",  0, 0, 0,            0, 0, 0, 12, 0);

      // overflow, saturation, underflow
      do_reset(3, 0);
      for (int i = 0; i < 4; i++) cyc("ovf3", 0, 0, 0, 1, 3, 0, 3, 0);
      for (int i = 0; i < 3; i++) cyc("drain3", 1, 3, 32'(i), 0, 0, 0, 3, 0);
      cyc("empty3",   0, 0, 0,            0, 0, 0, 3,  3);
      do_reset(3, 0);
      cyc("udf3",     1, 3, 32'h33,       0, 0, 0, 0,  0);
      cyc("udf3_chk", 0, 0, 0,            0, 0, 0, 3,  3);

      // flush with same-cycle issue and write
      do_reset(7, 0);
      cyc("iss7a",    0, 0, 0,            1, 7, 0, 7,  0);
      cyc("iss7b",    0, 0, 0,            1, 7, 0, 7,  0);
      cyc("flush7",   1, 7, 32'h55,       1, 7, 1, 7,  0);
      cyc("post7",    0, 0, 0,            0, 0, 0, 7,  7);
      cyc("iss7c",    0, 0, 0,            1, 7, 0, 7,  0);
      cyc("iss7d",    0, 0, 0,            1, 7, 0, 7,  8);
      do_reset(7, 8);
      cyc("rst7",     0, 0, 0,            0, 0, 0, 7,  8);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset(pick_addr(), pick_addr());
         end else begin
            cyc("rand", $urandom_range(0, 9) < 4, pick_addr(), $urandom,
                $urandom_range(0, 9) < 4, pick_addr(), $urandom_range(0, 99) < 3,
                pick_addr(), pick_addr());
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
